// File: rtl/serial_adder_if.sv
// Handshake and data bundle for serial_adder.
// Upstream drives operands and out_ready; serial_adder drives in_ready and the result.
// SERIAL_ADDER_SUB_EN adds the sub select sampled alongside the operands.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are accepted in parallel, pushed LSB-first through one
// Fulladder cell (carry held in a flop between bits), and the sum/carry-out returned in parallel.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub select for a - b).

// One-bit full adder cell shared across the codebase.
module Fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CntW-1:0]  count_q;

  logic             fa_b;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_sr_d;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  // Subtraction is a + ~b + 1: invert b on its way into the cell.
  assign fa_b = b_sr_q[0] ^ sub_q;
`else
  assign fa_b = b_sr_q[0];
`endif

  Fulladder u_fa (
    .a    (a_sr_q[0]),
    .b    (fa_b),
    .c    (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};

  // Control FSM and serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            count_q <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= bus.sub;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
`else
            carry_q <= bus.cin;
`endif
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d;
          carry_q  <= fa_cout;
          count_q  <= count_q + CntW'(1);
          if (count_q == LastCnt) begin
            sum_q   <= sum_sr_d;
            cout_q  <= fa_cout;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake flags decode straight from state so reset clears out_valid immediately.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); sub vectors run only when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand set and wait (bounded) for out_valid; result left in DONE.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output int lat);
    @(negedge clk);
    check_eq("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub       = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.cin      = ~cin;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("out_valid_after_consume", 32'(bus.out_valid), 32'd0);
    check_eq("in_ready_after_consume", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [7:0] exp_sum, input logic exp_cout);
    int lat;
    start_op(a, b, cin, sub, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'd8);
    check_eq({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check_eq({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    finish_op();
  endtask

  initial begin
    int lat;
    logic [7:0] held_sum;
    logic       held_cout;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    #3;
    check_eq("reset_sum", 32'(bus.sum), 32'd0);
    check_eq("reset_cout", 32'(bus.cout), 32'd0);
    check_eq("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
    #9 rst_n = 1'b1;

    run_vec("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
    run_vec("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_vec("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    run_vec("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
    run_vec("add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

    // Asynchronous reset mid-clock with a nonzero result held.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midclk_rst_sum", 32'(bus.sum), 32'd0);
    check_eq("midclk_rst_cout", 32'(bus.cout), 32'd0);
    check_eq("midclk_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midclk_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: result held in DONE while inputs churn.
    start_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
    check_eq("bp_latency", 32'(lat), 32'd8);
    held_sum  = bus.sum;
    held_cout = bus.cout;
    check_eq("bp_sum", 32'(held_sum), 32'h46);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a        = bus.a + 8'h11;
      bus.b        = bus.b ^ 8'hA5;
      @(posedge clk);
      #1;
      check_eq("bp_sum_stable", 32'(bus.sum), 32'(held_sum));
      check_eq("bp_cout_stable", 32'(bus.cout), 32'(held_cout));
      check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check_eq("bp_out_valid_high", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    finish_op();

    // Abort after 3 RUN cycles.
    start_op(8'hAA, 8'h55, 1'b1, 1'b0, lat);
    finish_op();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'hAA;
    bus.b        = 8'h55;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("abort_no_result", 32'(bus.out_valid), 32'd0);
    end
    run_vec("post_abort", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_vec("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_vec("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_vec("sub_off_add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
